// File: rtl/pheap_level_pkg.sv
// +--------------------------------------------------------------------------+
// | pheap_level_pkg : shared types and helpers for pipelined-heap levels     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pheap_level_pkg;

  localparam int PQ_LEVELS = 4;
  localparam int KEY_W     = 8;
  localparam int VAL_W     = 8;
  // Root capacity is 2**PQ_LEVELS-1, so PQ_LEVELS bits cover every level.
  localparam int CAP_W     = PQ_LEVELS;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;

  typedef struct packed {
    kv_t              kv;
    logic [CAP_W-1:0] cap;
    logic             active;
  } entry_t;

  typedef enum logic [1:0] {
    ENQ     = 2'd0,
    DEQ     = 2'd1,
    ENQ_DEQ = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    WAIT       = 2'd0,
    DONE       = 2'd1,
    NEXT_LEVEL = 2'd2
  } done_t;

  localparam kv_t    KV_EMPTY    = '0;
  localparam entry_t ENTRY_EMPTY = '0;

  // Strict ordering: equal keys never beat each other.
  function automatic logic beats(input logic min_heap, input kv_t a, input kv_t b);
    return min_heap ? (a.key < b.key) : (a.key > b.key);
  endfunction

  function automatic logic [CAP_W-1:0] cap_max(input int levels, input int level);
    return CAP_W'((1 << (levels - level + 1)) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pheap_level_mem.sv
// +--------------------------------------------------------------------------+
// | pheap_level_mem : entry register file, 1 write port, 2 pair-read ports   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pheap_level_mem
  import pheap_level_pkg::*;
#(
  parameter int     AW          = 1,
  parameter entry_t RESET_ENTRY = ENTRY_EMPTY,
  localparam int    PW          = (AW > 1) ? AW - 1 : 1,
  localparam int    N           = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [PW-1:0] ra_pair,
  output entry_t        ra_l,
  output entry_t        ra_r,
  input  logic [PW-1:0] rb_pair,
  output entry_t        rb_l,
  output entry_t        rb_r
);

  entry_t r_mem [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= RESET_ENTRY;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // A two-entry level has a single pair, so the pair indices carry no information.
  if (AW == 1) begin : g_single_pair
    logic w_unused_pair;
    assign w_unused_pair = ^{ra_pair, rb_pair};
    assign ra_l = r_mem[0];
    assign ra_r = r_mem[1];
    assign rb_l = r_mem[0];
    assign rb_r = r_mem[1];
  end else begin : g_multi_pair
    assign ra_l = r_mem[{ra_pair, 1'b0}];
    assign ra_r = r_mem[{ra_pair, 1'b1}];
    assign rb_l = r_mem[{rb_pair, 1'b0}];
    assign rb_r = r_mem[{rb_pair, 1'b1}];
  end

endmodule

`default_nettype wire

// File: rtl/pheap_level.sv
// +--------------------------------------------------------------------------+
// | pheap_level : interior/leaf level controller of the pipelined heap       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pheap_level
  import pheap_level_pkg::*;
#(
  parameter int  LEVEL    = 2,
  parameter int  LEVELS   = PQ_LEVELS,
  parameter bit  MIN_HEAP = 1'b0,
  localparam int AW       = LEVEL - 1,
  localparam int PW       = (LEVEL > 2) ? LEVEL - 2 : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  opcode_t       op,
  input  kv_t           in,
  input  logic [AW-1:0] addr,
  output done_t         done,
  input  logic [PW-1:0] raddrTop,
  output entry_t        rTopL,
  output entry_t        rTopR,
  output logic [AW-1:0] raddrBot,
  input  entry_t        rBotL,
  input  entry_t        rBotR,
  output logic          start_next,
  output opcode_t       op_next,
  output kv_t           out,
  output logic [AW:0]   addr_next,
  output logic          overflow
);

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  localparam logic [CAP_W-1:0] c_cap_max     = cap_max(LEVELS, LEVEL);
  localparam entry_t           c_reset_entry = '{kv: KV_EMPTY, cap: c_cap_max, active: 1'b0};

  state_t           r_state;
  state_t           w_state_next;
  opcode_t          r_op;
  kv_t              r_in;
  logic [AW-1:0]    r_addr;

  entry_t           w_own_l;
  entry_t           w_own_r;
  entry_t           w_cur;
  entry_t           w_cl;
  entry_t           w_cr;
  entry_t           w_wdata;
  kv_t              w_best_kv;
  logic             w_best_right;
  logic             w_any_child;
  logic             w_end_pos;
  logic             w_we;
  logic [PW-1:0]    w_own_pair;
  logic [CAP_W-1:0] w_cap_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= ENQ;
      r_in   <= KV_EMPTY;
      r_addr <= '0;
    end else if (r_state == IDLE && start) begin
      r_op   <= op;
      r_in   <= in;
      r_addr <= addr;
    end
  end

  pheap_level_mem #(
    .AW          (AW),
    .RESET_ENTRY (c_reset_entry)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (w_we),
    .waddr   (r_addr),
    .wdata   (w_wdata),
    .ra_pair (w_own_pair),
    .ra_l    (w_own_l),
    .ra_r    (w_own_r),
    .rb_pair (raddrTop),
    .rb_l    (rTopL),
    .rb_r    (rTopR)
  );

  if (AW == 1) begin : g_own_single_pair
    assign w_own_pair = '0;
  end else begin : g_own_pair
    assign w_own_pair = r_addr[AW-1:1];
  end

  assign w_cur = r_addr[0] ? w_own_r : w_own_l;

  // The bottom level has no children: they look permanently empty and full.
  if (LEVEL == LEVELS) begin : g_leaf
    logic w_unused_children;
    assign w_unused_children = ^{rBotL, rBotR};
    assign w_cl = ENTRY_EMPTY;
    assign w_cr = ENTRY_EMPTY;
  end else begin : g_interior
    assign w_cl = rBotL;
    assign w_cr = rBotR;
  end

  always_comb begin
    w_any_child = w_cl.active | w_cr.active;
    if (w_cl.active && w_cr.active) begin
      w_best_right = beats(MIN_HEAP, w_cr.kv, w_cl.kv);
    end else begin
      w_best_right = w_cr.active;
    end
    w_best_kv = w_best_right ? w_cr.kv : w_cl.kv;
    w_cap_inc = (w_cur.cap == c_cap_max) ? w_cur.cap : w_cur.cap + CAP_W'(1);
  end

  always_comb begin
    w_state_next = r_state;
    done         = DONE;
    start_next   = 1'b0;
    op_next      = r_op;
    out          = KV_EMPTY;
    overflow     = 1'b0;
    w_end_pos    = 1'b0;
    w_we         = 1'b0;
    w_wdata      = w_cur;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = UPDATE;
          done         = WAIT;
        end
      end
      UPDATE: begin
        w_state_next = IDLE;
        case (r_op)
          ENQ: begin
            if (w_cur.cap == '0) begin
              overflow = 1'b1;
            end else if (!w_cur.active) begin
              w_we           = 1'b1;
              w_wdata.kv     = r_in;
              w_wdata.cap    = w_cur.cap - CAP_W'(1);
              w_wdata.active = 1'b1;
            end else begin
              // Loser sinks toward the roomier subtree to keep the heap balanced.
              w_we        = 1'b1;
              w_wdata.cap = w_cur.cap - CAP_W'(1);
              start_next  = 1'b1;
              op_next     = ENQ;
              done        = NEXT_LEVEL;
              w_end_pos   = (w_cr.cap > w_cl.cap);
              if (beats(MIN_HEAP, r_in, w_cur.kv)) begin
                w_wdata.kv = r_in;
                out        = w_cur.kv;
              end else begin
                out        = r_in;
              end
            end
          end
          DEQ: begin
            if (w_cur.active) begin
              w_we        = 1'b1;
              w_wdata.cap = w_cap_inc;
              if (!w_any_child) begin
                w_wdata.kv     = KV_EMPTY;
                w_wdata.active = 1'b0;
              end else begin
                w_wdata.kv = w_best_kv;
                start_next = 1'b1;
                op_next    = DEQ;
                out        = w_best_kv;
                w_end_pos  = w_best_right;
                done       = NEXT_LEVEL;
              end
            end
          end
          ENQ_DEQ: begin
            w_we           = 1'b1;
            w_wdata.active = 1'b1;
            if (w_any_child && beats(MIN_HEAP, w_best_kv, r_in)) begin
              w_wdata.kv = w_best_kv;
              start_next = 1'b1;
              op_next    = ENQ_DEQ;
              out        = r_in;
              w_end_pos  = w_best_right;
              done       = NEXT_LEVEL;
            end else begin
              w_wdata.kv = r_in;
            end
          end
          default: ;
        endcase
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign raddrBot  = r_addr;
  assign addr_next = {r_addr, w_end_pos};

endmodule

`default_nettype wire

// File: tb/tb_pheap_level.sv
// +--------------------------------------------------------------------------+
// | tb_pheap_level : max L2, min L2 and leaf L4 controllers vs a key model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pheap_level;
  import pheap_level_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start;
  opcode_t    op;
  kv_t        kin;
  logic [2:0] addr;
  entry_t     bot_l, bot_r;
  logic [1:0] raddr_c;
  bit         checking;

  done_t   done_a, done_b, done_c;
  entry_t  tl_a, tr_a, tl_b, tr_b, tl_c, tr_c;
  logic    rb_a, rb_b;
  logic [2:0] rb_c;
  logic    sn_a, sn_b, sn_c, ovf_a, ovf_b, ovf_c;
  opcode_t opn_a, opn_b, opn_c;
  kv_t     out_a, out_b, out_c;
  logic [1:0] an_a, an_b;
  logic [3:0] an_c;

  pheap_level #(.LEVEL(2), .LEVELS(4), .MIN_HEAP(1'b0)) u_max (
    .clk(clk), .rst(rst), .start(start[0]), .op(op), .in(kin), .addr(addr[0:0]),
    .done(done_a), .raddrTop(1'b0), .rTopL(tl_a), .rTopR(tr_a), .raddrBot(rb_a),
    .rBotL(bot_l), .rBotR(bot_r), .start_next(sn_a), .op_next(opn_a), .out(out_a),
    .addr_next(an_a), .overflow(ovf_a));

  pheap_level #(.LEVEL(2), .LEVELS(4), .MIN_HEAP(1'b1)) u_min (
    .clk(clk), .rst(rst), .start(start[1]), .op(op), .in(kin), .addr(addr[0:0]),
    .done(done_b), .raddrTop(1'b0), .rTopL(tl_b), .rTopR(tr_b), .raddrBot(rb_b),
    .rBotL(bot_l), .rBotR(bot_r), .start_next(sn_b), .op_next(opn_b), .out(out_b),
    .addr_next(an_b), .overflow(ovf_b));

  pheap_level #(.LEVEL(4), .LEVELS(4), .MIN_HEAP(1'b0)) u_leaf (
    .clk(clk), .rst(rst), .start(start[2]), .op(op), .in(kin), .addr(addr),
    .done(done_c), .raddrTop(raddr_c), .rTopL(tl_c), .rTopR(tr_c), .raddrBot(rb_c),
    .rBotL(bot_l), .rBotR(bot_r), .start_next(sn_c), .op_next(opn_c), .out(out_c),
    .addr_next(an_c), .overflow(ovf_c));

  // Model state: entry contents per instance plus the expected UPDATE-cycle outputs.
  int     cap_mx [3] = '{7, 7, 1};
  bit     is_min [3] = '{1'b0, 1'b1, 1'b0};
  bit     is_leaf[3] = '{1'b0, 1'b0, 1'b1};
  int     n_ent  [3] = '{2, 2, 8};
  entry_t m_mem  [3][8];
  int     phase  [3];
  done_t  e_done [3];
  logic   e_sn   [3];
  opcode_t e_opn [3];
  kv_t    e_out  [3];
  int     e_an   [3];
  int     e_addr [3];
  logic   e_ovf  [3];
  bit     e_we   [3];
  entry_t e_new  [3];

  done_t  snap_done[3];
  logic   snap_sn  [3];
  logic   snap_ovf [3];
  kv_t    snap_out [3];
  int     snap_an  [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int inst, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h", name, inst, got, exp);
    end
  endtask

  function automatic entry_t ent(input int key, input int cap, input bit act);
    entry_t e;
    e.kv.key   = KEY_W'(key);
    e.kv.value = act ? VAL_W'(key + 50) : '0;
    e.cap      = CAP_W'(cap);
    e.active   = act;
    return e;
  endfunction

  // Higher score means higher priority, whichever way the heap is ordered.
  function automatic int score(input int i, input kv_t k);
    return is_min[i] ? -int'(k.key) : int'(k.key);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) begin
        m_mem[i][j] = ent(0, cap_mx[i], 1'b0);
      end
    end
  endtask

  task automatic forward(input int i, input opcode_t o, input kv_t k, input int child);
    e_sn[i]   = 1'b1;
    e_opn[i]  = o;
    e_out[i]  = k;
    e_an[i]   = child;
    e_done[i] = NEXT_LEVEL;
  endtask

  task automatic model(input int i, input opcode_t o, input kv_t k, input int a,
                       input entry_t l, input entry_t r);
    entry_t e;
    entry_t ch[2];
    int     best;
    e     = m_mem[i][a];
    ch[0] = is_leaf[i] ? ent(0, 0, 1'b0) : l;
    ch[1] = is_leaf[i] ? ent(0, 0, 1'b0) : r;
    best  = -1;
    for (int s = 0; s < 2; s++) begin
      if (ch[s].active && (best < 0 || score(i, ch[s].kv) > score(i, ch[best].kv))) best = s;
    end
    e_done[i] = DONE; e_sn[i] = 1'b0; e_opn[i] = o; e_out[i] = KV_EMPTY;
    e_an[i] = 0; e_ovf[i] = 1'b0; e_we[i] = 1'b0; e_new[i] = e; e_addr[i] = a;
    case (o)
      ENQ: begin
        if (e.cap == 0) begin
          e_ovf[i] = 1'b1;
        end else begin
          e_we[i] = 1'b1;
          e_new[i].cap = e.cap - CAP_W'(1);
          e_new[i].active = 1'b1;
          if (!e.active) begin
            e_new[i].kv = k;
          end else if (score(i, k) > score(i, e.kv)) begin
            e_new[i].kv = k;
            forward(i, ENQ, e.kv, 2 * a + ((ch[1].cap > ch[0].cap) ? 1 : 0));
          end else begin
            forward(i, ENQ, k, 2 * a + ((ch[1].cap > ch[0].cap) ? 1 : 0));
          end
        end
      end
      DEQ: begin
        if (e.active) begin
          e_we[i] = 1'b1;
          e_new[i].cap = (int'(e.cap) + 1 > cap_mx[i]) ? CAP_W'(cap_mx[i]) : e.cap + CAP_W'(1);
          if (best < 0) begin
            e_new[i].kv = KV_EMPTY;
            e_new[i].active = 1'b0;
          end else begin
            e_new[i].kv = ch[best].kv;
            forward(i, DEQ, ch[best].kv, 2 * a + best);
          end
        end
      end
      default: begin
        e_we[i] = 1'b1;
        e_new[i].active = 1'b1;
        if (best >= 0 && score(i, ch[best].kv) > score(i, k)) begin
          e_new[i].kv = ch[best].kv;
          forward(i, ENQ_DEQ, k, 2 * a + best);
        end else begin
          e_new[i].kv = k;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin : cmp
    done_t   g_done;
    logic    g_sn, g_ovf;
    opcode_t g_opn;
    kv_t     g_out;
    int      g_an, g_rb, pair;
    entry_t  g_tl, g_tr;
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0: begin g_done = done_a; g_sn = sn_a; g_ovf = ovf_a; g_opn = opn_a; g_out = out_a;
                   g_an = int'(an_a); g_rb = int'(rb_a); g_tl = tl_a; g_tr = tr_a; pair = 0; end
          1: begin g_done = done_b; g_sn = sn_b; g_ovf = ovf_b; g_opn = opn_b; g_out = out_b;
                   g_an = int'(an_b); g_rb = int'(rb_b); g_tl = tl_b; g_tr = tr_b; pair = 0; end
          default: begin g_done = done_c; g_sn = sn_c; g_ovf = ovf_c; g_opn = opn_c; g_out = out_c;
                   g_an = int'(an_c); g_rb = int'(rb_c); g_tl = tl_c; g_tr = tr_c; pair = int'(raddr_c); end
        endcase
        chk("rtop_l", i, 64'(g_tl), 64'(m_mem[i][2 * pair]));
        chk("rtop_r", i, 64'(g_tr), 64'(m_mem[i][2 * pair + 1]));
        if (phase[i] == 2) begin
          chk("done", i, 64'(g_done), 64'(e_done[i]));
          chk("start_next", i, 64'(g_sn), 64'(e_sn[i]));
          chk("overflow", i, 64'(g_ovf), 64'(e_ovf[i]));
          chk("out", i, 64'(g_out), 64'(e_out[i]));
          chk("raddr_bot", i, 64'(g_rb), 64'(e_addr[i]));
          if (e_sn[i]) begin
            chk("op_next", i, 64'(g_opn), 64'(e_opn[i]));
            chk("addr_next", i, 64'(g_an), 64'(e_an[i]));
          end
          snap_done[i] = g_done; snap_sn[i] = g_sn; snap_ovf[i] = g_ovf;
          snap_out[i] = g_out; snap_an[i] = g_an;
        end else begin
          chk("done", i, 64'(g_done), 64'((phase[i] == 1) ? WAIT : DONE));
          chk("start_next", i, 64'(g_sn), 64'(0));
          chk("overflow", i, 64'(g_ovf), 64'(0));
          chk("out", i, 64'(g_out), 64'(KV_EMPTY));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    raddr_c = raddr_c + 2'd1;
  endtask

  task automatic cmd(input int i, input opcode_t o, input int key, input int a,
                     input entry_t l, input entry_t r);
    op       = o;
    kin.key  = KEY_W'(key);
    kin.value = VAL_W'(key + 100);
    addr     = 3'(a);
    bot_l    = l;
    bot_r    = r;
    start[i] = 1'b1;
    phase[i] = 1;
    tick();
    start[i] = 1'b0;
    model(i, o, kin, a, l, r);
    phase[i] = 2;
    tick();
    if (e_we[i]) m_mem[i][a] = e_new[i];
    phase[i] = 0;
  endtask

  initial begin
    rst = 1'b0; start = '0; op = ENQ; kin = KV_EMPTY; addr = '0;
    bot_l = ENTRY_EMPTY; bot_r = ENTRY_EMPTY; raddr_c = '0;
    for (int i = 0; i < 3; i++) phase[i] = 0;
    reset_model();
    checking = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("lit_reset_cap", 0, 64'(tl_a.cap), 64'(7));
    chk("lit_reset_leaf_cap", 2, 64'(m_mem[2][3].cap), 64'(1));

    // Max-heap level 2
    cmd(0, ENQ, 5, 0, ent(0, 3, 0), ent(0, 2, 0));
    chk("lit_enq_empty_done", 0, 64'(snap_done[0]), 64'(DONE));
    chk("lit_enq_empty_entry", 0, 64'(tl_a), 64'(ent(5, 6, 1)) - 64'(50 << (CAP_W + 1)) + 64'(100 << (CAP_W + 1)));
    cmd(0, ENQ, 9, 0, ent(0, 3, 0), ent(0, 2, 0));
    chk("lit_enq_push_out", 0, 64'(snap_out[0].key), 64'(5));
    chk("lit_enq_push_addr", 0, 64'(snap_an[0]), 64'(0));
    chk("lit_enq_push_entry", 0, 64'({tl_a.kv.key, tl_a.cap}), 64'({8'd9, 4'd5}));
    cmd(0, ENQ, 3, 1, ent(0, 3, 0), ent(0, 3, 0));
    cmd(0, ENQ, 2, 1, ent(0, 2, 0), ent(0, 3, 0));
    chk("lit_enq_right_addr", 0, 64'(snap_an[0]), 64'(3));
    cmd(0, DEQ, 0, 0, ent(4, 2, 1), ent(7, 1, 1));
    chk("lit_deq_entry", 0, 64'({m_mem[0][0].kv.key, m_mem[0][0].cap}), 64'({8'd7, 4'd6}));
    chk("lit_deq_addr", 0, 64'(snap_an[0]), 64'(1));
    cmd(0, DEQ, 0, 1, ent(0, 3, 0), ent(0, 3, 0));
    chk("lit_deq_leafish_act", 0, 64'(tr_a.active), 64'(0));
    cmd(0, DEQ, 0, 1, ent(0, 3, 0), ent(0, 3, 0));
    cmd(0, ENQ_DEQ, 10, 0, ent(4, 2, 1), ent(7, 1, 1));
    cmd(0, ENQ_DEQ, 7, 0, ent(4, 2, 1), ent(7, 1, 1));
    chk("lit_enqdeq_equal_done", 0, 64'(snap_done[0]), 64'(DONE));
    cmd(0, ENQ_DEQ, 1, 0, ent(6, 2, 1), ent(6, 1, 1));
    chk("lit_enqdeq_tie_addr", 0, 64'(snap_an[0]), 64'(0));
    cmd(0, DEQ, 0, 0, ent(0, 3, 0), ent(0, 3, 0));
    cmd(0, ENQ_DEQ, 12, 0, ent(0, 3, 0), ent(0, 3, 0));
    cmd(0, DEQ, 0, 0, ent(0, 3, 0), ent(0, 3, 0));
    chk("lit_deq_saturate", 0, 64'(tl_a.cap), 64'(7));

    // Min-heap level 2
    cmd(1, ENQ_DEQ, 8, 1, ent(3, 3, 1), ent(6, 3, 1));
    chk("lit_min_entry", 1, 64'(tr_b.kv.key), 64'(3));
    chk("lit_min_out", 1, 64'(snap_out[1].key), 64'(8));
    chk("lit_min_addr", 1, 64'(snap_an[1]), 64'(2));
    cmd(1, ENQ, 4, 1, ent(1, 2, 1), ent(2, 3, 1));
    chk("lit_min_enq_out", 1, 64'(snap_out[1].key), 64'(4));

    // Leaf level 4
    cmd(2, ENQ, 4, 5, ent(0, 0, 0), ent(0, 0, 0));
    cmd(2, ENQ, 6, 5, ent(9, 3, 1), ent(9, 3, 1));
    chk("lit_leaf_overflow", 2, 64'(snap_ovf[2]), 64'(1));
    chk("lit_leaf_unchanged", 2, 64'(m_mem[2][5].kv.key), 64'(4));
    cmd(2, DEQ, 0, 5, ent(9, 3, 1), ent(8, 3, 1));
    chk("lit_leaf_deq_no_fwd", 2, 64'(snap_sn[2]), 64'(0));
    cmd(2, ENQ, 7, 2, ent(0, 0, 0), ent(0, 0, 0));

    // Reset in the middle of an UPDATE
    op = ENQ; kin.key = 8'd20; kin.value = 8'd120; addr = 3'd1;
    start[0] = 1'b1; phase[0] = 1;
    tick();
    start[0] = 1'b0;
    rst = 1'b0;
    reset_model();
    phase[0] = 0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("lit_midreset_cap", 0, 64'(tr_a.cap), 64'(7));
    chk("lit_midreset_done", 0, 64'(done_a), 64'(DONE));
    tick(); tick(); tick(); tick();

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
